// File: rtl/eeprom_pkg.sv
// ----------------------------------------------------------------------------
// eeprom_pkg
// Shared definitions for the 93C66 (x16, 256 word) serial EEPROM model:
//   - 2-bit opcodes and the extended sub-opcodes carried in addr[AW-1:AW-2]
//   - serial FSM state encoding and pending-commit kinds
//   - default self-timed programming length (CLK cycles)
//   - small integer max helper used for parameter arithmetic
// ----------------------------------------------------------------------------
package eeprom_pkg;

    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_ERASE = 2'b11;
    localparam logic [1:0] OP_EXT   = 2'b00;

    // extended commands: value of the two address MSBs when opcode is OP_EXT
    localparam logic [1:0] EXT_EWEN = 2'b11;
    localparam logic [1:0] EXT_EWDS = 2'b00;
    localparam logic [1:0] EXT_ERAL = 2'b10;
    localparam logic [1:0] EXT_WRAL = 2'b01;

    localparam int BUSY_CYCLES_DEF = 4800;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_OPC,
        ST_ADDR,
        ST_READ,
        ST_WDATA,
        ST_WAITCS,
        ST_BUSY
    } state_t;

    typedef enum logic [2:0] {
        PEND_NONE,
        PEND_WRITE,
        PEND_ERASE,
        PEND_ERAL,
        PEND_WRAL
    } pend_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/eeprom_sync_edge.sv
// ----------------------------------------------------------------------------
// eeprom_sync_edge
// Two-flop synchroniser for one asynchronous serial pin, plus a rising-edge
// detector on the synchronised level.
//   i_clk    system clock
//   i_rst_n  asynchronous active-low reset
//   i_d      asynchronous input pin
//   o_sync   synchronised level
//   o_rise   one-cycle pulse on a synchronised 0->1 transition
// ----------------------------------------------------------------------------
module eeprom_sync_edge (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_sync,
    output logic o_rise
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_sync = r_sync;
    assign o_rise = r_sync & ~r_prev;

endmodule

// File: rtl/eeprom_93c66.sv
// ----------------------------------------------------------------------------
// eeprom_93c66
// Behavioural 93C66 serial EEPROM (x16) answering the CPU's EEPROM pins, with
// a host port for restoring/dumping NVRAM contents. Single CLK domain; the
// serial pins are oversampled through eeprom_sync_edge.
//
// Ports
//   CLK        system clock (48 MHz)
//   RESET_N    asynchronous active-low reset
//   SCS        chip select, active high (async)
//   SCLK       serial clock (async, oversampled)
//   SDI        serial data in (async)
//   SDO        serial data out / ready-busy status
//   HOST_ADDR  host word address
//   HOST_DIN   host write data
//   HOST_WE    host write strobe (one cycle)
//   HOST_DOUT  host read data, registered, 1-cycle latency
//   DIRTY      set by the first array write of a committed serial command
//   DIRTY_CLR  clears DIRTY (loses to a simultaneous set)
//
// Build option
//   EEPROM_DUMMY_BIT_EN : when defined, a READ emits one leading 0 bit after
//                         the address before the first data MSB.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// IDLE     | chip deselected, SDO=1
// START    | selected, skipping leading zeros until the start bit
// OPC      | shifting the 2 opcode bits
// ADDR     | shifting AW address bits, decode on the last one
// READ     | shifting array data out on SDO, sequential across words
// WDATA    | shifting DW write-data bits
// WAITCS   | command complete, waiting for SCS fall to commit
// BUSY     | self-timed programming, SDO=0 while selected
// ----------------------------------------------------------------------------
module eeprom_93c66
    import eeprom_pkg::*;
#(
    parameter int AW          = 8,
    parameter int DW          = 16,
    parameter int BUSY_CYCLES = BUSY_CYCLES_DEF
) (
    input  logic          CLK,
    input  logic          RESET_N,
    input  logic          SCS,
    input  logic          SCLK,
    input  logic          SDI,
    output logic          SDO,
    input  logic [AW-1:0] HOST_ADDR,
    input  logic [DW-1:0] HOST_DIN,
    input  logic          HOST_WE,
    output logic [DW-1:0] HOST_DOUT,
    output logic          DIRTY,
    input  logic          DIRTY_CLR
);

`ifdef EEPROM_DUMMY_BIT_EN
    localparam bit DUMMY_EN = 1'b1;
`else
    localparam bit DUMMY_EN = 1'b0;
`endif

    localparam int NWORDS   = 1 << AW;
    localparam int BUSY_LEN = max_int(BUSY_CYCLES, NWORDS);
    localparam int BW       = $clog2(BUSY_LEN);
    localparam int CW       = $clog2(max_int(AW, DW));

    // synchronised pins
    logic w_scs;
    logic w_scs_rise;
    logic w_sdi;
    logic w_sdi_rise;
    logic w_sclk_sync;
    logic w_sclk_rise;
    logic w_unused_sync;

    eeprom_sync_edge u_sync_scs (
        .i_clk   (CLK),
        .i_rst_n (RESET_N),
        .i_d     (SCS),
        .o_sync  (w_scs),
        .o_rise  (w_scs_rise)
    );

    eeprom_sync_edge u_sync_sclk (
        .i_clk   (CLK),
        .i_rst_n (RESET_N),
        .i_d     (SCLK),
        .o_sync  (w_sclk_sync),
        .o_rise  (w_sclk_rise)
    );

    eeprom_sync_edge u_sync_sdi (
        .i_clk   (CLK),
        .i_rst_n (RESET_N),
        .i_d     (SDI),
        .o_sync  (w_sdi),
        .o_rise  (w_sdi_rise)
    );

    assign w_unused_sync = w_scs_rise | w_sdi_rise | w_sclk_sync;

    // registers
    state_t          r_state;
    state_t          w_state_nxt;
    pend_t           r_pend;
    logic [CW-1:0]   r_bitcnt;
    logic [1:0]      r_op;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_data;
    logic [DW-1:0]   r_shift;
    logic            r_dummy;
    logic            r_load;
    logic            r_ewen;
    logic [BW-1:0]   r_busy_cnt;
    logic [AW:0]     r_wr_left;
    logic [AW-1:0]   r_sweep_addr;
    logic            r_dirty;
    logic            r_dirty_arm;
    logic [DW-1:0]   r_mem_q;
    logic [DW-1:0]   r_host_dout;
    logic [DW-1:0]   r_mem [NWORDS];

    // combinational
    logic            w_act;
    logic            w_cnt_zero;
    logic [AW-1:0]   w_addr_full;
    state_t          w_dec_state;
    pend_t           w_dec_pend;
    logic            w_ewen_set;
    logic            w_ewen_clr;
    logic            w_busy_entry;
    logic            w_busy_done;
    logic            w_pend_sweep;
    logic            w_pend_fill;
    logic            w_ser_req;
    logic            w_ser_go;
    logic            w_mem_we;
    logic [AW-1:0]   w_mem_waddr;
    logic [DW-1:0]   w_mem_wdata;
    logic [AW-1:0]   w_raddr;
    logic            w_sdo;

    // serial clock edges only count while selected
    assign w_act        = w_sclk_rise & w_scs;
    assign w_cnt_zero   = (r_bitcnt == '0);
    assign w_addr_full  = {r_addr[AW-2:0], w_sdi};
    assign w_pend_sweep = (r_pend == PEND_ERAL) || (r_pend == PEND_WRAL);
    assign w_pend_fill  = (r_pend == PEND_ERASE) || (r_pend == PEND_ERAL);
    assign w_busy_done  = (r_busy_cnt == '0) && (r_wr_left == '0);

    // command decode on the last address bit
    always_comb begin
        w_dec_state = ST_WAITCS;
        w_dec_pend  = PEND_NONE;
        w_ewen_set  = 1'b0;
        w_ewen_clr  = 1'b0;
        case (r_op)
            OP_READ:  w_dec_state = ST_READ;
            OP_WRITE: begin
                w_dec_state = ST_WDATA;
                w_dec_pend  = PEND_WRITE;
            end
            OP_ERASE: w_dec_pend = PEND_ERASE;
            OP_EXT: begin
                case (w_addr_full[AW-1 -: 2])
                    EXT_EWEN: w_ewen_set = 1'b1;
                    EXT_EWDS: w_ewen_clr = 1'b1;
                    EXT_ERAL: w_dec_pend = PEND_ERAL;
                    EXT_WRAL: begin
                        w_dec_state = ST_WDATA;
                        w_dec_pend  = PEND_WRAL;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    // next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_scs) w_state_nxt = ST_START;
            ST_START:  if (w_act && w_sdi) w_state_nxt = ST_OPC;
            ST_OPC:    if (w_act && w_cnt_zero) w_state_nxt = ST_ADDR;
            ST_ADDR:   if (w_act && w_cnt_zero) w_state_nxt = w_dec_state;
            ST_WDATA:  if (w_act && w_cnt_zero) w_state_nxt = ST_WAITCS;
            ST_BUSY:   if (w_busy_done) w_state_nxt = ST_IDLE;
            default: ;
        endcase
        // deselect aborts everything except an armed commit or programming
        if (r_state != ST_BUSY && !w_scs) begin
            if (r_state == ST_WAITCS && r_pend != PEND_NONE && r_ewen)
                w_state_nxt = ST_BUSY;
            else
                w_state_nxt = ST_IDLE;
        end
    end

    assign w_busy_entry = (r_state == ST_WAITCS) && (w_state_nxt == ST_BUSY);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    // serial front end: shifters, decode side effects, read data path
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_pend   <= PEND_NONE;
            r_bitcnt <= '0;
            r_op     <= '0;
            r_addr   <= '0;
            r_data   <= '0;
            r_shift  <= '0;
            r_dummy  <= 1'b0;
            r_load   <= 1'b0;
            r_ewen   <= 1'b0;
        end else begin
            r_load <= 1'b0;
            if (r_state == ST_IDLE) r_pend <= PEND_NONE;
            if (w_act) begin
                case (r_state)
                    ST_START: r_bitcnt <= CW'(1);
                    ST_OPC: begin
                        r_op     <= {r_op[0], w_sdi};
                        r_bitcnt <= w_cnt_zero ? CW'(AW-1) : r_bitcnt - 1'b1;
                    end
                    ST_ADDR: begin
                        r_addr <= w_addr_full;
                        if (w_cnt_zero) begin
                            r_pend   <= w_dec_pend;
                            r_bitcnt <= CW'(DW-1);
                            r_load   <= (w_dec_state == ST_READ);
                            if (w_ewen_set) r_ewen <= 1'b1;
                            if (w_ewen_clr) r_ewen <= 1'b0;
                        end else begin
                            r_bitcnt <= r_bitcnt - 1'b1;
                        end
                    end
                    ST_WDATA: begin
                        r_data   <= {r_data[DW-2:0], w_sdi};
                        r_bitcnt <= r_bitcnt - 1'b1;
                    end
                    ST_READ: begin
                        if (r_dummy) begin
                            r_dummy <= 1'b0;
                        end else if (w_cnt_zero) begin
                            // r_mem_q already holds the following word
                            r_shift  <= r_mem_q;
                            r_addr   <= AW'(r_addr + 1'b1);
                            r_bitcnt <= CW'(DW-1);
                        end else begin
                            r_shift  <= {r_shift[DW-2:0], 1'b0};
                            r_bitcnt <= r_bitcnt - 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            if (r_load) begin
                r_shift <= r_mem_q;
                r_dummy <= DUMMY_EN;
            end
        end
    end

    // commit engine: busy timer, single write or full-array sweep, DIRTY
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_busy_cnt   <= '0;
            r_wr_left    <= '0;
            r_sweep_addr <= '0;
            r_dirty      <= 1'b0;
            r_dirty_arm  <= 1'b0;
        end else begin
            if (w_busy_entry) begin
                r_busy_cnt   <= BW'(BUSY_LEN - 1);
                r_wr_left    <= w_pend_sweep ? (AW+1)'(NWORDS) : (AW+1)'(1);
                r_sweep_addr <= '0;
                r_dirty_arm  <= 1'b1;
            end else if (r_state == ST_BUSY) begin
                if (r_busy_cnt != '0) r_busy_cnt <= r_busy_cnt - 1'b1;
                if (w_ser_go) begin
                    r_wr_left    <= r_wr_left - 1'b1;
                    r_sweep_addr <= r_sweep_addr + 1'b1;
                end
            end
            if (w_ser_go && r_dirty_arm) begin
                r_dirty     <= 1'b1;
                r_dirty_arm <= 1'b0;
            end else if (DIRTY_CLR) begin
                r_dirty <= 1'b0;
            end
        end
    end

    // single write port: a host write takes the port, the serial write retries
    assign w_ser_req   = (r_state == ST_BUSY) && (r_wr_left != '0);
    assign w_ser_go    = w_ser_req && !HOST_WE;
    assign w_mem_we    = HOST_WE || w_ser_go;
    assign w_mem_waddr = HOST_WE ? HOST_ADDR : (w_pend_sweep ? r_sweep_addr : r_addr);
    assign w_mem_wdata = HOST_WE ? HOST_DIN : (w_pend_fill ? {DW{1'b1}} : r_data);

    // serial read address: the addressed word while the last address bit
    // arrives, then always one word ahead for seamless sequential reads
    assign w_raddr = (r_state == ST_ADDR) ? w_addr_full : AW'(r_addr + 1'b1);

    always_ff @(posedge CLK) begin
        if (w_mem_we) r_mem[w_mem_waddr] <= w_mem_wdata;
    end

    always_ff @(posedge CLK) begin
        r_mem_q <= r_mem[w_raddr];
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) r_host_dout <= '0;
        else          r_host_dout <= r_mem[HOST_ADDR];
    end

    always_comb begin
        w_sdo = 1'b1;
        if (r_state == ST_READ)
            w_sdo = r_dummy ? 1'b0 : r_shift[DW-1];
        else if (r_state == ST_BUSY && w_scs)
            w_sdo = 1'b0;
    end

    assign SDO       = w_sdo;
    assign HOST_DOUT = r_host_dout;
    assign DIRTY     = r_dirty;

endmodule

// File: tb/tb_eeprom_93c66.sv
module tb_eeprom_93c66;

    localparam int BUSY     = 1000;
    localparam int BUSY_LEN = (BUSY > 256) ? BUSY : 256;
    localparam int HALF     = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        scs = 1'b0;
    logic        sclk = 1'b0;
    logic        sdi = 1'b0;
    logic [7:0]  host_addr = '0;
    logic [15:0] host_din = '0;
    logic        host_we = 1'b0;
    logic        dirty_clr = 1'b0;
    wire         sdo;
    wire [15:0]  host_dout;
    wire         dirty;

    logic [15:0] model [256];
    logic        ewen_m;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    eeprom_93c66 #(.AW(8), .DW(16), .BUSY_CYCLES(BUSY)) dut (
        .CLK       (clk),
        .RESET_N   (rst_n),
        .SCS       (scs),
        .SCLK      (sclk),
        .SDI       (sdi),
        .SDO       (sdo),
        .HOST_ADDR (host_addr),
        .HOST_DIN  (host_din),
        .HOST_WE   (host_we),
        .HOST_DOUT (host_dout),
        .DIRTY     (dirty),
        .DIRTY_CLR (dirty_clr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        sdi = b;
        repeat (HALF) tick();
        sclk = 1'b1;
        repeat (HALF) tick();
        sclk = 1'b0;
    endtask

    task automatic send_bits(input logic [15:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic recv_bits(input int n, output logic [15:0] v);
        v = '0;
        for (int i = 0; i < n; i++) begin
            repeat (HALF) tick();
            v = {v[14:0], sdo};
            sclk = 1'b1;
            repeat (HALF) tick();
            sclk = 1'b0;
        end
    endtask

    task automatic head(input logic [1:0] op, input logic [7:0] a, input int nz);
        scs = 1'b1;
        repeat (HALF) tick();
        repeat (nz) send_bit(1'b0);
        send_bit(1'b1);
        send_bits({14'b0, op}, 2);
        send_bits({8'b0, a}, 8);
    endtask

    task automatic end_cs();
        scs = 1'b0;
        repeat (HALF) tick();
    endtask

    task automatic read_cmd(input logic [7:0] a, input int nz, output logic [15:0] w);
        logic [15:0] dummy;
        head(2'b10, a, nz);
`ifdef EEPROM_DUMMY_BIT_EN
        recv_bits(1, dummy);
        chk("dummy_bit", {31'b0, dummy[0]}, 32'd0);
`else
        dummy = '0;
`endif
        recv_bits(16, w);
    endtask

    task automatic host_write(input logic [7:0] a, input logic [15:0] d);
        host_addr = a;
        host_din  = d;
        host_we   = 1'b1;
        tick();
        host_we   = 1'b0;
    endtask

    task automatic host_read(input logic [7:0] a, output logic [15:0] d);
        host_addr = a;
        tick();
        d = host_dout;
    endtask

    task automatic check_array(input string tag);
        logic [15:0] d;
        for (int i = 0; i < 256; i++) begin
            host_read(8'(i), d);
            chk($sformatf("%s[%02h]", tag, i), {16'b0, d}, {16'b0, model[i]});
        end
    endtask

    // drop SCS, optionally hit the host port mid-commit, reselect and wait
    task automatic commit(input int low_ticks, input bit hp,
                          input logic [7:0] a1, input logic [15:0] v1,
                          input logic [7:0] a2, input logic [15:0] v2,
                          output logic busy_seen, output int elapsed);
        scs = 1'b0;
        repeat (low_ticks) tick();
        elapsed = low_ticks;
        if (hp) begin
            host_write(a1, v1);
            host_write(a2, v2);
            elapsed += 2;
        end
        scs = 1'b1;
        repeat (4) tick();
        elapsed += 4;
        busy_seen = ~sdo;
        for (int i = 0; i < 3 * BUSY_LEN && sdo !== 1'b1; i++) begin
            tick();
            elapsed++;
        end
        chk("ready_after_commit", {31'b0, sdo}, 32'd1);
        end_cs();
    endtask

    task automatic chk_busy(input string tag, input logic bs, input int el, input logic exp_busy);
        chk({tag, "_busy"}, {31'b0, bs}, {31'b0, exp_busy});
        if (exp_busy)
            chk({tag, "_len"}, {31'b0, (el >= BUSY_LEN + 1 && el <= BUSY_LEN + 6)}, 32'd1);
    endtask

    logic [15:0] w, d, v1, v2;
    logic [7:0]  a, a1, a2;
    logic        bs;
    int          el;

    initial begin
        ewen_m = 1'b0;

        // reset state
        repeat (3) tick();
        chk("rst_sdo", {31'b0, sdo}, 32'd1);
        chk("rst_host_dout", {16'b0, host_dout}, 32'd0);
        chk("rst_dirty", {31'b0, dirty}, 32'd0);
        rst_n = 1'b1;
        repeat (3) tick();

        // preload array from the host side
        for (int i = 0; i < 256; i++) begin
            model[i] = 16'($urandom);
            host_write(8'(i), model[i]);
        end
        model[8'h05] = 16'h1234;
        host_write(8'h05, 16'h1234);
        tick();
        chk("host_no_dirty", {31'b0, dirty}, 32'd0);

        // plain READ
        read_cmd(8'h05, 0, w);
        end_cs();
        chk("read_05", {16'b0, w}, 32'h1234);

        // WRITE with EWEN clear after reset: nothing happens
        head(2'b01, 8'h10, 0);
        send_bits(16'h5A5A, 16);
        commit(HALF, 1'b0, 8'h0, 16'h0, 8'h0, 16'h0, bs, el);
        chk_busy("wr_disabled", bs, el, 1'b0);
        host_read(8'h10, d);
        chk("wr_disabled_mem", {16'b0, d}, {16'b0, model[8'h10]});

        // EWEN then WRITE
        head(2'b00, {2'b11, 6'($urandom)}, 0);
        end_cs();
        ewen_m = 1'b1;
        head(2'b01, 8'h10, 0);
        send_bits(16'h5A5A, 16);
        commit(HALF, 1'b0, 8'h0, 16'h0, 8'h0, 16'h0, bs, el);
        model[8'h10] = 16'h5A5A;
        chk_busy("wr_enabled", bs, el, 1'b1);
        host_read(8'h10, d);
        chk("wr_enabled_mem", {16'b0, d}, 32'h5A5A);
        chk("dirty_set", {31'b0, dirty}, 32'd1);
        dirty_clr = 1'b1;
        tick();
        dirty_clr = 1'b0;
        tick();
        chk("dirty_clr", {31'b0, dirty}, 32'd0);

        // sequential read across the address wrap
        read_cmd(8'hFF, 0, w);
        recv_bits(16, d);
        end_cs();
        chk("seq_ff", {16'b0, w}, {16'b0, model[8'hFF]});
        chk("seq_00", {16'b0, d}, {16'b0, model[8'h00]});

        // random WRITE / ERASE commits read back serially
        for (int k = 0; k < 4; k++) begin
            a = 8'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                head(2'b11, a, 0);
                d = 16'hFFFF;
            end else begin
                d = 16'($urandom);
                head(2'b01, a, 0);
                send_bits(d, 16);
            end
            commit(HALF, 1'b0, 8'h0, 16'h0, 8'h0, 16'h0, bs, el);
            if (ewen_m) model[a] = d;
            chk_busy("rnd_commit", bs, el, ewen_m);
            read_cmd(a, 0, w);
            end_cs();
            chk("rnd_readback", {16'b0, w}, {16'b0, model[a]});
        end

        // EWDS blocks writes, EWEN re-enables
        head(2'b00, {2'b00, 6'($urandom)}, 0);
        end_cs();
        ewen_m = 1'b0;
        a = 8'($urandom);
        head(2'b01, a, 0);
        send_bits(16'($urandom), 16);
        commit(HALF, 1'b0, 8'h0, 16'h0, 8'h0, 16'h0, bs, el);
        chk_busy("ewds_write", bs, el, 1'b0);
        host_read(a, d);
        chk("ewds_mem", {16'b0, d}, {16'b0, model[a]});
        head(2'b00, {2'b11, 6'($urandom)}, 0);
        end_cs();
        ewen_m = 1'b1;

        // ERAL
        head(2'b00, {2'b10, 6'($urandom)}, 0);
        commit(HALF, 1'b0, 8'h0, 16'h0, 8'h0, 16'h0, bs, el);
        for (int i = 0; i < 256; i++) model[i] = 16'hFFFF;
        chk_busy("eral", bs, el, 1'b1);
        check_array("eral");

        // WRAL with host writes landing mid-sweep
        a1 = 8'($urandom_range(10, 60));
        a2 = 8'($urandom_range(200, 250));
        v1 = 16'($urandom);
        v2 = 16'($urandom);
        head(2'b00, {2'b01, 6'($urandom)}, 0);
        send_bits(16'h00C3, 16);
        commit(123, 1'b1, a1, v1, a2, v2, bs, el);
        for (int i = 0; i < 256; i++) model[i] = 16'h00C3;
        model[a1] = v1;
        chk_busy("wral", bs, el, 1'b1);
        check_array("wral");

        // reset in the middle of WDATA
        a = 8'($urandom);
        head(2'b01, a, 0);
        send_bits(16'hA5A5, 8);
        rst_n = 1'b0;
        repeat (2) tick();
        chk("midrst_sdo", {31'b0, sdo}, 32'd1);
        chk("midrst_dirty", {31'b0, dirty}, 32'd0);
        rst_n = 1'b1;
        ewen_m = 1'b0;
        end_cs();
        head(2'b01, a, 0);
        send_bits(16'h1111, 16);
        commit(HALF, 1'b0, 8'h0, 16'h0, 8'h0, 16'h0, bs, el);
        chk_busy("midrst_ewen", bs, el, 1'b0);
        check_array("midrst");

        // deselect mid-address, next command decodes cleanly
        scs = 1'b1;
        repeat (HALF) tick();
        send_bit(1'b1);
        send_bits(16'h2, 2);
        send_bits(16'($urandom), 4);
        end_cs();
        a = 8'($urandom);
        read_cmd(a, 0, w);
        end_cs();
        chk("abort_then_read", {16'b0, w}, {16'b0, model[a]});

        // SCLK activity while deselected, then leading zeros
        for (int i = 0; i < 5; i++) send_bit(1'($urandom));
        a = 8'($urandom);
        read_cmd(a, 3, w);
        end_cs();
        chk("lead_zero_read", {16'b0, w}, {16'b0, model[a]});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: observed no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule
